// File: rtl/ifetch_pc_ctrl_pkg.sv
// rtl/ifetch_pc_ctrl_pkg.sv - shared types and defaults for the instruction-fetch PC sequencer
package ifetch_pc_ctrl_pkg;

  // Default instruction-address width and memory read latency
  localparam int PC_W_DEF   = 10;
  localparam int RD_LAT_DEF = 1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    TERM  = 2'd3
  } ifpc_state_t;

endpackage

// File: rtl/ifetch_pc_ctrl_rd_pipe.sv
// rtl/ifetch_pc_ctrl_rd_pipe.sv - RD_LAT-deep {valid, pc} shift register with squash
module ifetch_pc_ctrl_rd_pipe
  import ifetch_pc_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue,
  input  logic            squash,
  input  logic [PC_W-1:0] issue_pc,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic            pending
);

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    logic v;
    pc_t  pc;
  } rd_pipe_t;

  rd_pipe_t stage [RD_LAT];

  // Shift each issued read towards the output; a squash kills every valid in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0].v  <= issue & ~squash;
      stage[0].pc <= issue_pc;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i].v  <= stage[i-1].v & ~squash;
        stage[i].pc <= stage[i-1].pc;
      end
    end
  end

  // Reads still on their way, excluding the one presented this cycle
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | stage[i].v;
  end

  // The read arriving in the squash cycle is itself in flight, so it is masked too
  assign out_valid = stage[RD_LAT-1].v & ~squash;
  assign out_pc    = stage[RD_LAT-1].pc;

endmodule

// File: rtl/ifetch_pc_ctrl.sv
// rtl/ifetch_pc_ctrl.sv - program-counter sequencer driving the instruction memory and IFetch stage
module ifetch_pc_ctrl
  import ifetch_pc_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            I_Start,
  input  logic [PC_W-1:0] I_Start_PC,
  input  logic [PC_W-1:0] I_End_PC,
  input  logic            I_Empty,
  input  logic            I_Stall,
  input  logic            I_Br_Taken,
  input  logic [PC_W-1:0] I_Br_Target,
  input  logic            I_Abort,
  output logic            O_Re_Instr,
  output logic [PC_W-1:0] O_Addr,
  output logic            O_Valid,
  output logic [PC_W-1:0] O_PC,
  output logic            O_Busy,
  output logic            O_Term
);

  typedef logic [PC_W-1:0] pc_t;

  ifpc_state_t state;
  pc_t         pc;
  pc_t         end_pc;
  logic        active;
  logic        squash;
  logic        rd_issue;
  logic        pending;

  // Abort and branch only matter while a program is being fetched
  assign active   = (state == RUN) || (state == DRAIN);
  assign squash   = active & (I_Abort | I_Br_Taken);
  assign rd_issue = (state == RUN) & ~I_Abort & ~I_Br_Taken & ~I_Stall;

  // Sequencer: reset > abort > branch > stall > increment
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      end_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_Start) begin
            if (I_Empty) begin
              state <= TERM;
            end else begin
              pc     <= I_Start_PC;
              end_pc <= I_End_PC;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (I_Abort) begin
            state <= TERM;
          end else if (I_Br_Taken) begin
            pc <= I_Br_Target;
          end else if (!I_Stall) begin
            pc <= pc + pc_t'(1);
            if (pc == end_pc) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (I_Abort) begin
            state <= TERM;
          end else if (I_Br_Taken) begin
            pc    <= I_Br_Target;
            state <= RUN;
          end else if (!pending) begin
            state <= TERM;
          end
        end
        TERM: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ifetch_pc_ctrl_rd_pipe #(
    .PC_W   (PC_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .issue     (rd_issue),
    .squash    (squash),
    .issue_pc  (pc),
    .out_valid (O_Valid),
    .out_pc    (O_PC),
    .pending   (pending)
  );

  assign O_Re_Instr = rd_issue;
  assign O_Addr     = pc;
  assign O_Busy     = (state != IDLE);
  assign O_Term     = (state == TERM);

endmodule

// File: tb/tb_ifetch_pc_ctrl.sv
// tb/tb_ifetch_pc_ctrl.sv - self-checking bench for ifetch_pc_ctrl (two configurations side by side)
module tb_ifetch_pc_ctrl;

  localparam int L0 = 1;
  localparam int L1 = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_TERM = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, empty = 1'b0, stall = 1'b0, br = 1'b0, abort = 1'b0;
  logic [9:0] spc = '0, epc = '0, tgt = '0;

  logic       re0, valid0, busy0, term0;
  logic [9:0] addr0, pc0;
  logic       re1, valid1, busy1, term1;
  logic [3:0] addr1, pc1;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int now = 0;
  int n_del0 = 0;
  string del0 = "";
  string del1 = "";
  logic [47:0] obs_vec, exp_vec;

  typedef struct {
    int k;
    int pc;
    int due;
  } fl_t;
  fl_t fq[$];
  int m_st[2]  = '{0, 0};
  int m_pc[2]  = '{0, 0};
  int m_end[2] = '{0, 0};

  always #5 clock = ~clock;

  ifetch_pc_ctrl #(.PC_W(10), .RD_LAT(L0)) u_dut0 (
    .clock(clock), .reset(reset), .I_Start(start), .I_Start_PC(spc), .I_End_PC(epc),
    .I_Empty(empty), .I_Stall(stall), .I_Br_Taken(br), .I_Br_Target(tgt), .I_Abort(abort),
    .O_Re_Instr(re0), .O_Addr(addr0), .O_Valid(valid0), .O_PC(pc0), .O_Busy(busy0), .O_Term(term0)
  );

  ifetch_pc_ctrl #(.PC_W(4), .RD_LAT(L1)) u_dut1 (
    .clock(clock), .reset(reset), .I_Start(start), .I_Start_PC(spc[3:0]), .I_End_PC(epc[3:0]),
    .I_Empty(empty), .I_Stall(stall), .I_Br_Taken(br), .I_Br_Target(tgt[3:0]), .I_Abort(abort),
    .O_Re_Instr(re1), .O_Addr(addr1), .O_Valid(valid1), .O_PC(pc1), .O_Busy(busy1), .O_Term(term1)
  );

  task automatic drop_inst(input int k);
    for (int i = fq.size() - 1; i >= 0; i--)
      if (fq[i].k == k) fq.delete(i);
  endtask

  // Reference: reads are a list of {pc, delivery cycle}; outputs for this cycle, then next state
  task automatic model_cycle(input int k, output logic eb, output logic et, output logic er,
                             output logic ev, output int ea, output int ep);
    int   mask, lat, idx;
    logic sq, pend;
    fl_t  e;
    mask = (k == 0) ? 1023 : 15;
    lat  = (k == 0) ? L0 : L1;
    eb = (m_st[k] != S_IDLE);
    et = (m_st[k] == S_TERM);
    sq = (m_st[k] == S_RUN || m_st[k] == S_DRAIN) && (abort || br);
    er = (m_st[k] == S_RUN) && !abort && !br && !stall;
    ea = m_pc[k];
    ev = 1'b0;
    ep = 0;
    idx = -1;
    for (int i = 0; i < fq.size(); i++)
      if (fq[i].k == k && fq[i].due == cyc) idx = i;
    if (idx >= 0) begin
      ev = !sq;
      ep = fq[idx].pc;
      fq.delete(idx);
    end
    if (sq) drop_inst(k);
    if (er) begin
      e.k = k; e.pc = m_pc[k]; e.due = cyc + lat;
      fq.push_back(e);
    end
    pend = 1'b0;
    for (int i = 0; i < fq.size(); i++)
      if (fq[i].k == k) pend = 1'b1;
    if (reset) begin
      drop_inst(k);
      m_st[k] = S_IDLE; m_pc[k] = 0; m_end[k] = 0;
    end else begin
      case (m_st[k])
        S_IDLE: if (start) begin
          if (empty) m_st[k] = S_TERM;
          else begin
            m_pc[k] = spc & mask; m_end[k] = epc & mask; m_st[k] = S_RUN;
          end
        end
        S_RUN: begin
          if (abort) m_st[k] = S_TERM;
          else if (br) m_pc[k] = tgt & mask;
          else if (!stall) begin
            if (m_pc[k] == m_end[k]) m_st[k] = S_DRAIN;
            m_pc[k] = (m_pc[k] + 1) % (mask + 1);
          end
        end
        S_DRAIN: begin
          if (abort) m_st[k] = S_TERM;
          else if (br) begin
            m_pc[k] = tgt & mask; m_st[k] = S_RUN;
          end else if (!pend) m_st[k] = S_TERM;
        end
        default: m_st[k] = S_IDLE;
      endcase
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0; empty = 1'b0; stall = 1'b0; br = 1'b0; abort = 1'b0;
  endtask

  task automatic eval_cycle();
    logic eb0, et0, er0, ev0, eb1, et1, er1, ev1;
    int   ea0, ep0, ea1, ep1;
    #4;
    model_cycle(0, eb0, et0, er0, ev0, ea0, ep0);
    model_cycle(1, eb1, et1, er1, ev1, ea1, ep1);
    exp_vec = {eb0, et0, er0, ev0, er0 ? 10'(ea0) : 10'd0, ev0 ? 10'(ep0) : 10'd0,
               eb1, et1, er1, ev1, er1 ? 10'(ea1) : 10'd0, ev1 ? 10'(ep1) : 10'd0};
    obs_vec = {busy0, term0, re0, valid0, er0 ? addr0 : 10'd0, ev0 ? pc0 : 10'd0,
               busy1, term1, re1, valid1, er1 ? {6'd0, addr1} : 10'd0, ev1 ? {6'd0, pc1} : 10'd0};
    if (valid0) begin del0 = {del0, $sformatf("%0d ", pc0)}; n_del0++; end
    if (valid1) del1 = {del1, $sformatf("%0d ", pc1)};
    now = cyc;
    cyc++;
  endtask

  task automatic clear_log();
    del0 = ""; del1 = ""; n_del0 = 0;
  endtask

  task automatic test_reset();
    next_cycle(); reset = 1'b1; eval_cycle();
    next_cycle(); reset = 1'b1; eval_cycle();
    tests_run++;
    if (obs_vec !== exp_vec) begin
      tests_failed++; $display("FAIL reset_model cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
    end
    tests_run++;
    if ({re0, valid0, busy0, term0, addr0, pc0, re1, valid1, busy1, term1, addr1, pc1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_zero got=%b want=0",
               {re0, valid0, busy0, term0, addr0, pc0, re1, valid1, busy1, term1, addr1, pc1});
    end
  endtask

  task automatic test_linear();
    clear_log();
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd4; epc = 10'd7; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL linear cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (i == 6) begin
        tests_run++;
        if (term0 !== 1'b1 || valid0 !== 1'b0) begin
          tests_failed++; $display("FAIL linear_term got term=%b valid=%b want term=1 valid=0", term0, valid0);
        end
      end
      if (i == 7) begin
        tests_run++;
        if (busy0 !== 1'b0 || term1 !== 1'b1) begin
          tests_failed++; $display("FAIL linear_idle got busy0=%b term1=%b want 0 1", busy0, term1);
        end
      end
    end
    tests_run++;
    if (del0 != "4 5 6 7 " || del1 != "4 5 6 7 ") begin
      tests_failed++; $display("FAIL linear_pcs got '%s' / '%s' want '4 5 6 7 '", del0, del1);
    end
  endtask

  task automatic test_stall();
    int stall_left = 0;
    logic armed = 1'b0;
    logic chk_next = 1'b0;
    clear_log();
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd4; epc = 10'd9; end
      if (stall_left > 0) begin stall = 1'b1; stall_left--; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL stall cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (stall) begin
        tests_run++;
        if (re0 !== 1'b0) begin tests_failed++; $display("FAIL stall_re got=%b want=0", re0); end
        chk_next = (stall_left == 0);
      end else if (chk_next) begin
        chk_next = 1'b0;
        tests_run++;
        if (re0 !== 1'b1 || addr0 !== 10'd6) begin
          tests_failed++; $display("FAIL stall_resume got re=%b addr=%0d want re=1 addr=6", re0, addr0);
        end
      end
      if (!armed && re0 && addr0 == 10'd5) begin armed = 1'b1; stall_left = 2; end
    end
    tests_run++;
    if (del0 != "4 5 6 7 8 9 " || del1 != "4 5 6 7 8 9 ") begin
      tests_failed++; $display("FAIL stall_pcs got '%s' / '%s' want '4 5 6 7 8 9 '", del0, del1);
    end
  endtask

  task automatic test_branch();
    logic fire = 1'b0;
    logic after = 1'b0;
    clear_log();
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd0; epc = 10'd20; end
      if (fire) begin br = 1'b1; tgt = 10'd16; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL branch cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (after) begin
        after = 1'b0;
        tests_run++;
        if (re0 !== 1'b1 || addr0 !== 10'd16) begin
          tests_failed++; $display("FAIL branch_target got re=%b addr=%0d want re=1 addr=16", re0, addr0);
        end
      end
      if (fire) begin
        fire = 1'b0; after = 1'b1;
        tests_run++;
        if (valid0 !== 1'b0 || re0 !== 1'b0) begin
          tests_failed++; $display("FAIL branch_squash got valid=%b re=%b want 0 0", valid0, re0);
        end
      end
      if (i < 6 && re0 && addr0 == 10'd2) fire = 1'b1;
    end
    tests_run++;
    if (del0 != "0 1 16 17 18 19 20 " || del1 != "0 0 1 2 3 4 ") begin
      tests_failed++;
      $display("FAIL branch_pcs got '%s' / '%s' want '0 1 16 17 18 19 20 ' / '0 0 1 2 3 4 '", del0, del1);
    end
  endtask

  task automatic test_wrap();
    logic done = 1'b0;
    clear_log();
    for (int i = 0; i < 1200 && !done; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd14; epc = 10'd1; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL wrap cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (i > 0 && !busy0 && !busy1) done = 1'b1;
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL wrap_timeout got busy=%b%b want 00", busy0, busy1); end
    tests_run++;
    if (del1 != "14 15 0 1 " || n_del0 != 1012) begin
      tests_failed++; $display("FAIL wrap_pcs got '%s' n0=%0d want '14 15 0 1 ' n0=1012", del1, n_del0);
    end
  endtask

  task automatic test_empty_abort();
    clear_log();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; empty = 1'b1; spc = 10'd3; epc = 10'd5; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL empty cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (i == 1) begin
        tests_run++;
        if ({term0, term1, re0, re1} !== 4'b1100) begin
          tests_failed++; $display("FAIL empty_term got %b want 1100", {term0, term1, re0, re1});
        end
      end
    end
    clear_log();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd0; epc = 10'd20; end
      if (i == 5) abort = 1'b1;
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL abort cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (i == 5 || i == 6) begin
        tests_run++;
        if (valid1 !== 1'b0 || valid0 !== 1'b0) begin
          tests_failed++; $display("FAIL abort_squash i=%0d got valid=%b%b want 00", i, valid0, valid1);
        end
      end
      if (i == 6) begin
        tests_run++;
        if (term0 !== 1'b1 || term1 !== 1'b1) begin
          tests_failed++; $display("FAIL abort_term got %b%b want 11", term0, term1);
        end
      end
    end
    tests_run++;
    if (del0 != "0 1 2 " || del1 != "0 1 ") begin
      tests_failed++; $display("FAIL abort_pcs got '%s' / '%s' want '0 1 2 ' / '0 1 '", del0, del1);
    end
  endtask

  task automatic test_reset_drain();
    logic done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      next_cycle();
      if (i == 0) begin start = 1'b1; spc = 10'd3; epc = 10'd3; end
      if (i == 2) reset = 1'b1;
      if (i == 3) begin start = 1'b1; spc = 10'd8; epc = 10'd9; end
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL rst_drain cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
      if (i == 2) begin
        tests_run++;
        if (busy1 !== 1'b1 || re1 !== 1'b0) begin
          tests_failed++; $display("FAIL rst_drain_pre got busy1=%b re1=%b want 1 0", busy1, re1);
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({re0, valid0, busy0, term0, addr0, pc0, re1, valid1, busy1, term1, addr1, pc1} !== '0) begin
          tests_failed++; $display("FAIL rst_drain_zero got %b want 0",
                                   {re0, valid0, busy0, term0, re1, valid1, busy1, term1});
        end
      end
      if (i == 4) begin
        tests_run++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
          tests_failed++; $display("FAIL rst_drain_restart got busy=%b%b want 11", busy0, busy1);
        end
      end
      if (i > 4 && !busy0 && !busy1) done = 1'b1;
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL rst_drain_timeout got busy=%b%b want 00", busy0, busy1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      start = ($urandom_range(0, 7) == 0);
      spc   = 10'($urandom_range(0, 1023));
      epc   = spc + 10'($urandom_range(0, 10));
      empty = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = spc + 10'($urandom_range(0, 15));
      abort = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 79) == 0);
      eval_cycle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++; $display("FAIL random cyc=%0d got=%h want=%h", now, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_stall();
    test_branch();
    test_wrap();
    test_empty_abort();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
